// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding and default width for the pipelined N:1 word mux.
package mux_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam int MUX_DEFAULT_WIDTH = 32;
endpackage

// File: rtl/mux_n_1_comb.sv
// mux_n_1_comb: combinational N:1 word select with DEFAULT_VAL fallback and out-of-range flag.
module mux_n_1_comb import mux_pkg::*; #(
    parameter int WIDTH = MUX_DEFAULT_WIDTH,
    parameter int NUM_IN = 3,
    parameter int SEL_W = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    out_of_range
);
    always_comb begin
        data = DEFAULT_VAL;
        out_of_range = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                out_of_range = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_n_1_pipe.sv
// mux_n_1_pipe: N:1 word mux with registered valid/ready output and two-entry skid buffer.
// MUX_SEL_CHECK_EN enables the sticky out-of-range select flag sel_err.
module mux_n_1_pipe import mux_pkg::*; #(
    parameter int WIDTH = MUX_DEFAULT_WIDTH,
    parameter int NUM_IN = 3,
    parameter int SEL_W = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
);
    state_t state;
    logic [WIDTH-1:0] main_q, skid_q, word;
    logic oor, accept, consume;

    mux_n_1_comb #(
        .WIDTH(WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W(SEL_W),
        .DEFAULT_VAL(DEFAULT_VAL)
    ) u_sel (
        .in_data(in_data),
        .sel(sel),
        .data(word),
        .out_of_range(oor)
    );

    assign in_ready = state != TWO;
    assign out_valid = state != EMPTY;
    assign out_data = main_q;
    assign accept = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_q <= word;
                    state <= ONE;
                end
                ONE: begin
                    if (accept && consume) main_q <= word;
                    else if (accept) begin
                        skid_q <= word;
                        state <= TWO;
                    end else if (consume) state <= EMPTY;
                end
                TWO: if (consume) begin
                    main_q <= skid_q;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef MUX_SEL_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err <= 1'b0;
        else if (flush) sel_err <= 1'b0;
        else if (accept && oor) sel_err <= 1'b1;
    end
`else
    logic unused_oor;
    assign unused_oor = oor;
    assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_n_1_pipe.sv
// tb_mux_n_1_pipe: directed plus random stimulus against a queue-based reference model.
module tb_mux_n_1_pipe;
    logic clk = 0, rst_n = 0;
    logic [31:0] words [3];
    logic [95:0] in_data;
    logic [1:0] sel = 0;
    logic in_valid = 0, out_ready = 0, flush = 0;
    logic in_ready, out_valid, sel_err;
    logic [31:0] out_data;
    logic [31:0] exp_q [$];
    logic err_m = 0;
    int total = 0, passed = 0;
`ifdef MUX_SEL_CHECK_EN
    localparam bit CHECK = 1;
`else
    localparam bit CHECK = 0;
`endif

    always #5 clk = ~clk;
    assign in_data = {words[2], words[1], words[0]};

    mux_n_1_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .sel_err(sel_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_word(input logic [1:0] s);
        return s < 3 ? words[s] : 32'h0;
    endfunction

    // Model: occupancy is the queue length, capacity two words, flush empties everything.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_m = 0;
        end else begin
            automatic bit rdy = exp_q.size() < 2;
            chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            chk("sel_err", {31'b0, sel_err}, {31'b0, err_m});
            if (flush) begin
                exp_q.delete();
                err_m = 0;
            end else begin
                if (out_ready && exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
                if (in_valid && rdy) begin
                    exp_q.push_back(ref_word(sel));
                    if (sel >= 3 && CHECK) err_m = 1;
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [1:0] s, input logic ordy, input logic fl);
        in_valid = iv;
        sel = s;
        out_ready = ordy;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        words[0] = 32'h0000FFF0;
        words[1] = 32'h00000000;
        words[2] = 32'hFF00FFF0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sel_err", {31'b0, sel_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        drive(1, 0, 1, 0);
        drive(1, 2, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 2, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        repeat (3) drive(1, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 1);
        drive(0, 0, 1, 0);
        drive(1, 3, 1, 0);
        repeat (3) drive(1, 2, 1, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        drive(1, 2, 0, 0);
        #1 rst_n = 0;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_in_ready", {31'b0, in_ready}, 32'd1);
        chk("async_out_data", out_data, 32'd0);
        chk("async_sel_err", {31'b0, sel_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 500; i++) begin
            words[0] = $urandom;
            words[1] = $urandom;
            words[2] = $urandom;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
